// File: rtl/seq_red_reduce.sv
// rtl/seq_red_reduce.sv - multi-cycle OR/AND/XOR/XNOR reduction, chunk bits per cycle
// Valid/ready on both sides; all outputs registered or decoded from state.
module seq_red_reduce #(
  parameter int width = 32,
  parameter int chunk = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [width-1:0] A,
  input  logic [1:0]       Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Z,
  output logic             Busy
);

  localparam int NBEATS = (width + chunk - 1) / chunk;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(NBEATS - 1);
  localparam logic [width-1:0] ONES    = '1;
  localparam logic [width-1:0] LO_MASK = ONES >> (width - chunk);

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] opnd_q, opnd_d;
  logic [1:0]       op_q, op_d;
  logic             acc_q, acc_d;
  logic             z_q, z_d;

  logic [31:0]      base;
  logic [width-1:0] sh;
  logic [width-1:0] valid_mask;
  logic             fold_bit;
  logic             acc_new;

  // Bits past the operand top are masked to the op's identity, so padding never decides the result.
  always_comb begin
    base       = 32'(cnt_q) * 32'(chunk);
    sh         = opnd_q >> base;
    valid_mask = LO_MASK & (ONES >> base);
    fold_bit   = 1'b0;
    acc_new    = 1'b0;
    case (op_q)
      OP_OR: begin
        fold_bit = |(sh & valid_mask);
        acc_new  = acc_q | fold_bit;
      end
      OP_AND: begin
        fold_bit = &(sh | ~valid_mask);
        acc_new  = acc_q & fold_bit;
      end
      default: begin
        fold_bit = ^(sh & valid_mask);
        acc_new  = acc_q ^ fold_bit;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    acc_d   = acc_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (InValid) begin
          opnd_d  = A;
          op_d    = Op;
          acc_d   = (Op == OP_AND);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_new;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          z_d     = (op_q == OP_XNOR) ? ~acc_new : acc_new;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (OutReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      acc_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign OutValid = (state_q == S_DONE);
  assign Busy     = (state_q != S_IDLE);
  assign Z        = z_q;

endmodule

// File: tb/tb_seq_red_reduce.sv
// tb/tb_seq_red_reduce.sv - directed bench for seq_red_reduce, 32/8 and 10/4 instances
// Reference result comes from a bit-count model of each reduction.
module tb_seq_red_reduce;

  localparam int NB32 = 4;
  localparam int NB10 = 3;

  logic        clk;
  logic        rst;
  logic        iv32, ir32, ov32, ordy32, z32, busy32;
  logic [31:0] a32;
  logic [1:0]  op32;
  logic        iv10, ir10, ov10, ordy10, z10, busy10;
  logic [9:0]  a10;
  logic [1:0]  op10;

  int unsigned cyc;
  int          n_cmp, n_bad;

  // Handshake counters between driver and compare process
  int acc_id32, seen_id32, abort_id32, acc_cyc32;
  int acc_id10, seen_id10, abort_id10, acc_cyc10;
  logic exp32, exp10;
  logic pov32, pz32, pov10, pz10;

  seq_red_reduce #(.width(32), .chunk(8)) u32 (
    .CLK(clk), .RST(rst), .InValid(iv32), .InReady(ir32), .A(a32), .Op(op32),
    .OutValid(ov32), .OutReady(ordy32), .Z(z32), .Busy(busy32)
  );

  seq_red_reduce #(.width(10), .chunk(4)) u10 (
    .CLK(clk), .RST(rst), .InValid(iv10), .InReady(ir10), .A(a10), .Op(op10),
    .OutValid(ov10), .OutReady(ordy10), .Z(z10), .Busy(busy10)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic ref_red(input logic [31:0] a, input int w, input logic [1:0] op);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(a[i]);
    case (op)
      2'b00:   return ones > 0;
      2'b01:   return ones == w;
      2'b10:   return (ones % 2) == 1;
      default: return (ones % 2) == 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (acc_id32 != seen_id32 && acc_id32 != abort_id32 && ov32) begin
      chk("latency32", cyc - acc_cyc32, NB32);
      chk("model32", {31'b0, z32}, {31'b0, exp32});
      seen_id32 = acc_id32;
    end
    if (acc_id10 != seen_id10 && acc_id10 != abort_id10 && ov10) begin
      chk("latency10", cyc - acc_cyc10, NB10);
      chk("model10", {31'b0, z10}, {31'b0, exp10});
      seen_id10 = acc_id10;
    end
    if (ov32 && pov32) chk("hold32", {31'b0, z32}, {31'b0, pz32});
    if (ov10 && pov10) chk("hold10", {31'b0, z10}, {31'b0, pz10});
    chk("ready_vs_busy32", {31'b0, ir32}, {31'b0, ~busy32});
    chk("ready_vs_busy10", {31'b0, ir10}, {31'b0, ~busy10});
    pov32 = ov32; pz32 = z32;
    pov10 = ov10; pz10 = z10;
  end

  task automatic start(input int d, input logic [31:0] a, input logic [1:0] op, input logic lit);
    int n;
    n = 0;
    while (!(d == 0 ? ir32 : ir10) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("start_timeout", 32'd1, 32'd0);
    if (d == 0) begin
      iv32 = 1'b1; a32 = a; op32 = op;
    end else begin
      iv10 = 1'b1; a10 = a[9:0]; op10 = op;
    end
    @(negedge clk);
    if (d == 0) begin
      iv32 = 1'b0;
      acc_cyc32 = cyc;
      exp32 = ref_red(a, 32, op);
      chk("model_pin32", {31'b0, exp32}, {31'b0, lit});
      acc_id32++;
    end else begin
      iv10 = 1'b0;
      acc_cyc10 = cyc;
      exp10 = ref_red(a, 10, op);
      chk("model_pin10", {31'b0, exp10}, {31'b0, lit});
      acc_id10++;
    end
  endtask

  task automatic wait_done(input int d, input logic lit, input string nm);
    int n;
    n = 0;
    while (!(d == 0 ? ov32 : ov10) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({nm, "_timeout"}, 32'd1, 32'd0);
    else chk(nm, {31'b0, (d == 0 ? z32 : z10)}, {31'b0, lit});
  endtask

  task automatic run(input int d, input logic [31:0] a, input logic [1:0] op, input logic lit,
                     input string nm);
    start(d, a, op, lit);
    wait_done(d, lit, nm);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    acc_id32 = 0; seen_id32 = 0; abort_id32 = -1; acc_cyc32 = 0;
    acc_id10 = 0; seen_id10 = 0; abort_id10 = -1; acc_cyc10 = 0;
    exp32 = 0; exp10 = 0; pov32 = 0; pz32 = 0; pov10 = 0; pz10 = 0;
    rst = 1'b1;
    iv32 = 1'b1; a32 = 32'hFFFF_FFFF; op32 = 2'b01; ordy32 = 1'b1;
    iv10 = 1'b1; a10 = 10'h3FF;       op10 = 2'b01; ordy10 = 1'b1;

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; iv32 = 1'b0; iv10 = 1'b0;
    chk("rst_inready", {31'b0, ir32}, 32'd1);
    chk("rst_outvalid", {31'b0, ov32}, 32'd0);
    chk("rst_z", {31'b0, z32}, 32'd0);
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_busy10", {31'b0, busy10}, 32'd0);
    @(negedge clk);
    chk("no_capture_busy", {31'b0, busy32}, 32'd0);

    run(0, 32'h0000_0000, 2'b00, 1'b0, "or_zero");
    run(0, 32'h8000_0000, 2'b00, 1'b1, "or_msb");
    run(0, 32'hFFFF_FFFF, 2'b01, 1'b1, "and_ones");
    run(0, 32'hFFFF_FFFE, 2'b01, 1'b0, "and_lsb0");
    run(0, 32'h0000_0007, 2'b10, 1'b1, "xor_7");
    run(0, 32'h0000_0007, 2'b11, 1'b0, "xnor_7");
    run(0, 32'hA5A5_0F0F, 2'b10, 1'b0, "xor_mix");

    run(1, 32'h0000_03FF, 2'b01, 1'b1, "pad_and");
    run(1, 32'h0000_0201, 2'b10, 1'b0, "pad_xor");
    run(1, 32'h0000_0200, 2'b00, 1'b1, "pad_or_top");
    run(1, 32'h0000_01FF, 2'b11, 1'b0, "pad_xnor");

    ordy32 = 1'b0;
    run(0, 32'h8000_0000, 2'b00, 1'b1, "bp_result");
    for (int i = 0; i < 10; i++) begin
      chk("bp_outvalid", {31'b0, ov32}, 32'd1);
      chk("bp_z", {31'b0, z32}, 32'd1);
      chk("bp_inready", {31'b0, ir32}, 32'd0);
      iv32 = ~iv32;
      a32 = $urandom;
      op32 = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    iv32 = 1'b0;
    ordy32 = 1'b1;
    @(negedge clk);
    chk("bp_release_ov", {31'b0, ov32}, 32'd0);
    chk("bp_release_ir", {31'b0, ir32}, 32'd1);
    chk("bp_z_kept", {31'b0, z32}, 32'd1);

    start(0, 32'hFFFF_FFFF, 2'b01, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    abort_id32 = acc_id32;
    rst = 1'b0;
    chk("midrun_ov", {31'b0, ov32}, 32'd0);
    chk("midrun_z", {31'b0, z32}, 32'd0);
    chk("midrun_busy", {31'b0, busy32}, 32'd0);
    chk("midrun_ir", {31'b0, ir32}, 32'd1);
    run(0, 32'h0000_0001, 2'b00, 1'b1, "after_reset_or");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
